mem_access_unit: RTL and testbench

Single-ported memory execution unit directly downstream of the memory issue queue. It accepts one issued load or store uop per request, together with its register-read operands, and computes the effective address. It performs one data-memory transaction over a valid/ready request channel and a valid-only response channel, then presents the aligned and extended result for writeback. It drives `ex_busy` back to the issue queue so that no new memory uop is issued while a transaction is in flight.

---
 rtl/mem_access_unit_if.sv | 47 ++++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Shared uop type and the data-memory request/response bundle of the memory unit.
package mem_access_unit_pkg;

    typedef enum logic {
        MEM_LD = 1'b0,
        MEM_ST = 1'b1
    } mem_type_e;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2
    } mem_size_e;

    typedef struct packed {
        logic       valid;
        mem_type_e  mem_type;
        mem_size_e  mem_size;
        logic       mem_unsigned;
        logic [11:0] imm;
        logic [4:0]  rd;
    } micro_op_t;

endpackage

interface mem_access_unit_if #(
    parameter int XLEN = 32
);
    logic            dmem_req_valid;
    logic            dmem_req_ready;
    logic [XLEN-1:0] dmem_addr;
    logic            dmem_we;
    logic [3:0]      dmem_wstrb;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_resp_valid;
    logic [XLEN-1:0] dmem_resp_data;

    modport master (
        output dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
        input  dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );

    modport slave (
        input  dmem_req_valid, dmem_addr, dmem_we, dmem_wstrb, dmem_wdata,
        output dmem_req_ready, dmem_resp_valid, dmem_resp_data
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory execution unit: one load/store at a time, address generation,
// lane alignment of store data, load extraction/extension and writeback.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear_en,
    input  micro_op_t        uop_in,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    output logic             ex_busy,
    mem_access_unit_if.master dmem,
    output logic             wb_valid,
    output micro_op_t        wb_uop,
    output logic [XLEN-1:0]  wb_data,
    output logic             wb_misaligned
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    micro_op_t       uop_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] sdata_q;
    logic [XLEN-1:0] rdata_q;
    logic            misal_q;

    logic [XLEN-1:0] eff_addr;
    logic            misal_acc;
    logic            accept;
    logic            is_st;

    // Byte enables for the access size, moved up to the addressed lane.
    function automatic logic [3:0] lane_strb(mem_size_e sz, logic [1:0] ofs);
        logic [3:0] base;
        case (sz)
            MEM_B:   base = 4'b0001;
            MEM_H:   base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << ofs;
    endfunction

    // Bring the addressed bytes down to bit 0 and extend them to XLEN.
    function automatic logic [XLEN-1:0] load_ext(logic [XLEN-1:0] word, mem_size_e sz,
                                                 logic uns, logic [1:0] ofs);
        logic [XLEN-1:0] sh;
        logic [XLEN-1:0] res;
        sh = word >> {ofs, 3'b000};
        case (sz)
            MEM_B:   res = uns ? {{(XLEN-8){1'b0}}, sh[7:0]}
                           : {{(XLEN-8){sh[7]}}, sh[7:0]};
            MEM_H:   res = uns ? {{(XLEN-16){1'b0}}, sh[15:0]}
                           : {{(XLEN-16){sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign eff_addr = rs1_data + {{(XLEN-12){uop_in.imm[11]}}, uop_in.imm};
    assign accept   = (state_q == S_IDLE) && uop_in.valid && !clear_en;
    assign is_st    = (uop_q.mem_type == MEM_ST);

    // Alignment of the incoming access; byte accesses are never misaligned.
    always_comb begin
        misal_acc = 1'b0;
        case (uop_in.mem_size)
            MEM_H:   misal_acc = eff_addr[0];
            MEM_W:   misal_acc = (eff_addr[1:0] != 2'b00);
            default: misal_acc = 1'b0;
        endcase
    end

    // Next state; flush wins over every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = misal_acc ? S_DONE : S_REQ;
            end
            S_REQ: begin
                if (clear_en)                   state_d = S_IDLE;
                else if (dmem.dmem_req_ready)   state_d = is_st ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                // A response arriving with the flush is the one being discarded.
                if (clear_en)                   state_d = dmem.dmem_resp_valid ? S_IDLE : S_DRAIN;
                else if (dmem.dmem_resp_valid)  state_d = S_DONE;
            end
            S_DRAIN: begin
                if (dmem.dmem_resp_valid)       state_d = S_IDLE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Held uop, address, store data and read data; cleared so outputs reset to 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            uop_q   <= '0;
            addr_q  <= '0;
            sdata_q <= '0;
            rdata_q <= '0;
            misal_q <= 1'b0;
        end else begin
            if (accept) begin
                uop_q   <= uop_in;
                addr_q  <= eff_addr;
                sdata_q <= rs2_data;
                rdata_q <= '0;
                misal_q <= misal_acc;
            end else if (state_q == S_WAIT && dmem.dmem_resp_valid && !clear_en) begin
                rdata_q <= dmem.dmem_resp_data;
            end
        end
    end

    assign ex_busy             = (state_q != S_IDLE);
    assign dmem.dmem_req_valid = (state_q == S_REQ);
    assign dmem.dmem_addr      = {addr_q[XLEN-1:2], 2'b00};
    assign dmem.dmem_we        = is_st;
    assign dmem.dmem_wstrb     = is_st ? lane_strb(uop_q.mem_size, addr_q[1:0]) : 4'b0000;
    assign dmem.dmem_wdata     = is_st ? (sdata_q << {addr_q[1:0], 3'b000}) : '0;

    assign wb_valid      = (state_q == S_DONE);
    assign wb_uop        = uop_q;
    assign wb_misaligned = misal_q && (state_q == S_DONE);
    assign wb_data       = is_st ? '0
                         : load_ext(rdata_q, uop_q.mem_size, uop_q.mem_unsigned, addr_q[1:0]);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level expected timeline plus a
// per-cycle compare process, directed scenarios and randomized transactions.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear_en = 1'b0;
    micro_op_t   uop_in;
    logic [31:0] rs1_data, rs2_data;
    logic        ex_busy, wb_valid, wb_misaligned;
    micro_op_t   wb_uop;
    logic [31:0] wb_data;

    mem_access_unit_if #(.XLEN(32)) dmem_if();

    mem_access_unit #(.XLEN(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .clear_en      (clear_en),
        .uop_in        (uop_in),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .ex_busy       (ex_busy),
        .dmem          (dmem_if),
        .wb_valid      (wb_valid),
        .wb_uop        (wb_uop),
        .wb_data       (wb_data),
        .wb_misaligned (wb_misaligned)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic        e_busy = 1'b0, e_req = 1'b0, e_wb = 1'b0, e_mis = 1'b0, e_we = 1'b0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_wbdata = '0;
    logic [3:0]  e_strb = '0;
    micro_op_t   e_uop = '0;

    logic [31:0] cap_addr = '0, cap_wdata = '0, cap_wbdata = '0;
    logic [3:0]  cap_strb = '0;
    logic        cap_mis = 1'b0;
    int          wb_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_strb(mem_size_e sz, logic [1:0] o);
        int n;
        n = (sz == MEM_B) ? 1 : (sz == MEM_H) ? 3 : 15;
        return 4'(n << o);
    endfunction

    function automatic logic [31:0] exp_load(logic [31:0] w, mem_size_e sz, logic uns, logic [1:0] o);
        longint v;
        v = longint'(w >> (8 * o));
        case (sz)
            MEM_B: begin v = v % 256;   if (!uns && v >= 128)   v -= 256;   end
            MEM_H: begin v = v % 65536; if (!uns && v >= 32768) v -= 65536; end
            default: v = longint'(w);
        endcase
        return 32'(v);
    endfunction

    // Per-cycle comparison against the expected timeline.
    always @(negedge clock) begin
        chk("ex_busy", 32'(ex_busy), 32'(e_busy));
        chk("req_valid", 32'(dmem_if.dmem_req_valid), 32'(e_req));
        chk("wb_valid", 32'(wb_valid), 32'(e_wb));
        if (e_req && dmem_if.dmem_req_valid) begin
            chk("req_addr", dmem_if.dmem_addr, e_addr);
            chk("req_we", 32'(dmem_if.dmem_we), 32'(e_we));
            chk("req_wstrb", 32'(dmem_if.dmem_wstrb), 32'(e_strb));
            if (e_we) chk("req_wdata", dmem_if.dmem_wdata, e_wdata);
            cap_addr  = dmem_if.dmem_addr;
            cap_strb  = dmem_if.dmem_wstrb;
            cap_wdata = dmem_if.dmem_wdata;
        end
        if (e_wb && wb_valid) begin
            chk("wb_misaligned", 32'(wb_misaligned), 32'(e_mis));
            chk("wb_uop", 32'(wb_uop), 32'(e_uop));
            if (!e_mis) chk("wb_data", wb_data, e_wbdata);
            cap_wbdata = wb_data;
            cap_mis    = wb_misaligned;
        end
        if (wb_valid) wb_cnt++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        e_busy = 1'b0; e_req = 1'b0; e_wb = 1'b0;
    endtask

    task automatic idle_inputs();
        uop_in = 22'($urandom);
        uop_in.valid = 1'b0;
        rs1_data = $urandom;
        rs2_data = $urandom;
        clear_en = 1'b0;
        dmem_if.dmem_req_ready  = 1'($urandom_range(0, 1));
        dmem_if.dmem_resp_valid = 1'b0;
        dmem_if.dmem_resp_data  = $urandom;
    endtask

    // Busy-cycle inputs: junk uops that must not be accepted.
    task automatic busy_inputs();
        uop_in = 22'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        clear_en = 1'b0;
        dmem_if.dmem_req_ready  = 1'b0;
        dmem_if.dmem_resp_valid = 1'b0;
        dmem_if.dmem_resp_data  = $urandom;
    endtask

    // fmode: 0 none, 1 flush in REQ cycle fcyc (ready low), 2 flush in WAIT cycle fcyc (1..ndly).
    task automatic run_txn(input micro_op_t u, input logic [31:0] rs1, input logic [31:0] rs2,
                           input int rdly, input int ndly, input int fmode, input int fcyc,
                           input logic [31:0] rdata);
        logic [31:0] a;
        logic [1:0]  o;
        logic        mis, st;
        a   = rs1 + {{20{u.imm[11]}}, u.imm};
        o   = a[1:0];
        st  = (u.mem_type == MEM_ST);
        mis = (u.mem_size == MEM_H && o[0]) || (u.mem_size == MEM_W && o != 2'b00);
        e_uop = u; e_mis = mis;
        e_addr = {a[31:2], 2'b00};
        e_we = st;
        e_strb = st ? exp_strb(u.mem_size, o) : 4'b0000;
        e_wdata = st ? (rs2 << (8 * o)) : 32'h0;
        e_wbdata = st ? 32'h0 : exp_load(rdata, u.mem_size, u.mem_unsigned, o);
        set_idle(); idle_inputs();
        uop_in = u; rs1_data = rs1; rs2_data = rs2;
        step();
        if (mis) begin
            busy_inputs();
            e_busy = 1'b1; e_wb = 1'b1;
            step();
        end else begin
            for (int i = 0; i <= rdly; i++) begin
                busy_inputs();
                e_busy = 1'b1; e_req = 1'b1;
                dmem_if.dmem_req_ready = (i == rdly);
                if (fmode == 1 && i == fcyc) begin
                    clear_en = 1'b1;
                    dmem_if.dmem_req_ready = 1'b0;
                    step();
                    set_idle(); idle_inputs();
                    return;
                end
                step();
            end
            e_req = 1'b0;
            if (!st) begin
                for (int j = 1; j <= ndly; j++) begin
                    busy_inputs();
                    dmem_if.dmem_resp_valid = (j == ndly);
                    if (j == ndly) dmem_if.dmem_resp_data = rdata;
                    if (fmode == 2 && j == fcyc) clear_en = 1'b1;
                    else if (fmode == 2 && j > fcyc) clear_en = 1'($urandom_range(0, 1));
                    step();
                end
            end
            if (!(fmode == 2 && !st)) begin
                busy_inputs();
                e_wb = 1'b1;
                step();
            end
        end
        set_idle(); idle_inputs();
    endtask

    function automatic micro_op_t mk(input mem_type_e t, input mem_size_e s, input logic uns,
                                     input logic [11:0] imm);
        micro_op_t u;
        u = '0;
        u.valid = 1'b1; u.mem_type = t; u.mem_size = s; u.mem_unsigned = uns; u.imm = imm;
        u.rd = 5'($urandom);
        return u;
    endfunction

    initial begin
        int          saved;
        micro_op_t   u;
        set_idle(); idle_inputs();
        step(); step();
        chk("reset_busy", 32'(ex_busy), 32'h0);
        chk("reset_req", 32'(dmem_if.dmem_req_valid), 32'h0);
        chk("reset_addr", dmem_if.dmem_addr, 32'h0);
        chk("reset_wb", {wb_valid, wb_misaligned, dmem_if.dmem_we, dmem_if.dmem_wstrb}, 32'h0);
        chk("reset_wbdata", wb_data, 32'h0);
        chk("reset_uop", 32'(wb_uop), 32'h0);
        reset = 1'b1;
        step();

        run_txn(mk(MEM_ST, MEM_W, 1'b0, 12'd4), 32'h1000, 32'hDEADBEEF, 0, 1, 0, 0, 32'h0);
        chk("st_w_addr", cap_addr, 32'h0000_1004);
        chk("st_w_strb", 32'(cap_strb), 32'hF);
        chk("st_w_wdata", cap_wdata, 32'hDEADBEEF);
        chk("st_w_wbdata", cap_wbdata, 32'h0);

        run_txn(mk(MEM_LD, MEM_B, 1'b0, 12'd0), 32'h1003, 32'h0, 0, 3, 0, 0, 32'h80AA55CC);
        chk("ld_b_signed", cap_wbdata, 32'hFFFFFF80);
        run_txn(mk(MEM_LD, MEM_B, 1'b1, 12'd0), 32'h1003, 32'h0, 0, 3, 0, 0, 32'h80AA55CC);
        chk("ld_b_unsigned", cap_wbdata, 32'h00000080);

        run_txn(mk(MEM_ST, MEM_H, 1'b0, 12'd0), 32'h2002, 32'h1234ABCD, 4, 1, 0, 0, 32'h0);
        chk("st_h_strb", 32'(cap_strb), 32'hC);
        chk("st_h_wdata", cap_wdata, 32'hABCD0000);

        run_txn(mk(MEM_LD, MEM_W, 1'b0, 12'd0), 32'h3001, 32'h0, 0, 1, 0, 0, 32'h0);
        chk("ld_w_misaligned", 32'(cap_mis), 32'h1);

        saved = wb_cnt;
        run_txn(mk(MEM_LD, MEM_W, 1'b0, 12'hFFC), 32'h4004, 32'h0, 0, 3, 2, 1, 32'h5555AAAA);
        chk("flush_no_wb", wb_cnt, saved);
        run_txn(mk(MEM_LD, MEM_H, 1'b0, 12'd2), 32'h4000, 32'h0, 1, 2, 0, 0, 32'h9876_0000);
        chk("after_flush_ld", cap_wbdata, 32'hFFFF9876);

        // Asynchronous reset while a request is pending.
        set_idle(); idle_inputs();
        uop_in = mk(MEM_ST, MEM_W, 1'b0, 12'd0); rs1_data = 32'h50; rs2_data = 32'h1111_2222;
        step();
        busy_inputs();
        e_busy = 1'b1; e_req = 1'b1; e_addr = 32'h50; e_we = 1'b1; e_strb = 4'hF; e_wdata = 32'h1111_2222;
        chk("pre_reset_req", 32'(dmem_if.dmem_req_valid), 32'h1);
        #1 reset = 1'b0; set_idle();
        #1;
        chk("async_rst_busy", 32'(ex_busy), 32'h0);
        chk("async_rst_req", 32'(dmem_if.dmem_req_valid), 32'h0);
        chk("async_rst_fields", dmem_if.dmem_addr | dmem_if.dmem_wdata | 32'(dmem_if.dmem_wstrb), 32'h0);
        chk("async_rst_wb", {wb_valid, wb_misaligned, dmem_if.dmem_we}, 32'h0);
        step(); idle_inputs(); step();
        reset = 1'b1;
        step();
        run_txn(mk(MEM_ST, MEM_B, 1'b0, 12'd1), 32'h60, 32'h0000_00A5, 0, 1, 0, 0, 32'h0);
        chk("post_reset_strb", 32'(cap_strb), 32'h2);
        chk("post_reset_wdata", cap_wdata, 32'h0000_A500);

        // Flush wins over acceptance in IDLE.
        saved = wb_cnt;
        set_idle(); idle_inputs();
        uop_in = mk(MEM_ST, MEM_W, 1'b0, 12'd0); clear_en = 1'b1;
        step();
        idle_inputs();
        step(); step();
        chk("idle_flush_no_wb", wb_cnt, saved);

        for (int n = 0; n < 80; n++) begin
            int r, rd, nd, fm, fc;
            u  = mk(mem_type_e'($urandom_range(0, 1)), mem_size_e'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 12'($urandom));
            rd = $urandom_range(0, 3);
            nd = $urandom_range(1, 4);
            r  = $urandom_range(0, 9);
            fm = 0; fc = 0;
            if (r == 1 && rd > 0) begin fm = 1; fc = $urandom_range(0, rd - 1); end
            if (r == 2) begin fm = 2; fc = $urandom_range(1, nd); end
            run_txn(u, $urandom, $urandom, rd, nd, fm, fc, $urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
